// File: rtl/dram_rd_sched.sv
// dram_rd_sched
//   Shares the single DRAM read port between two burst requesters
//   (0 = weight fetcher, 1 = feature-map fetcher). Grants round-robin,
//   issues one read address per cycle, and steers returned words to the
//   owning requester with a per-requester valid and a burst-done pulse.
//
// Ports
//   clk, srstn                 clock, synchronous active-low reset
//   req0/1, base0/1, len0/1    burst request, held until ack
//   ack0/1                     one-cycle accept pulse (registered)
//   rvalid0/1, rdata           returned word and its owner (combinational)
//   done0/1                    pulse with the last word of the burst
//   dram_en_rd, dram_addr_rd   DRAM read command (registered)
//   dram_valid, dram_data_out  DRAM read return
module dram_rd_sched #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned LEN_WIDTH    = 10,
    parameter int unsigned DRAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  srstn,
    input  logic                  req0,
    input  logic [ADDR_WIDTH-1:0] base0,
    input  logic [LEN_WIDTH-1:0]  len0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] base1,
    input  logic [LEN_WIDTH-1:0]  len1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done0,
    output logic                  done1,
    output logic                  dram_en_rd,
    output logic [ADDR_WIDTH-1:0] dram_addr_rd,
    input  logic                  dram_valid,
    input  logic [DATA_WIDTH-1:0] dram_data_out
);

    // Returns are counted rather than timed, so any fixed latency of at
    // least one cycle works; zero would let a return share the issue cycle.
    if (DRAM_LATENCY < 1) begin : g_latency_check
        $error("dram_rd_sched: DRAM_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t                state;
    logic                  owner;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issue_cnt;
    logic [LEN_WIDTH-1:0]  ret_cnt;

    logic                  grant_sel;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [LEN_WIDTH-1:0]  next_issue;
    logic [LEN_WIDTH-1:0]  next_ret;
    logic                  active;
    logic                  beat;
    logic                  last_beat;
    logic                  zero_done;
    logic                  done_any;

    // Arbitration: a tie goes to the requester not granted last time.
    always_comb begin
        grant_sel  = (req0 && req1) ? ~last_grant : req1;
        sel_base   = grant_sel ? base1 : base0;
        sel_len    = grant_sel ? len1  : len0;
        next_issue = issue_cnt + 1'b1;
        next_ret   = ret_cnt + 1'b1;
    end

    // Return path. Beats beyond the burst length are dropped so a stray
    // valid cannot disturb the counters.
    always_comb begin
        active    = (state == BURST) || (state == DRAIN);
        beat      = active && dram_valid && (ret_cnt != len_q);
        last_beat = beat && (next_ret == len_q);
        zero_done = (state == DRAIN) && (len_q == '0);
        done_any  = last_beat || zero_done;
        rvalid0   = beat && !owner;
        rvalid1   = beat && owner;
        rdata     = beat ? dram_data_out : '0;
        done0     = done_any && !owner;
        done1     = done_any && owner;
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state        <= IDLE;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            base_q       <= '0;
            len_q        <= '0;
            issue_cnt    <= '0;
            ret_cnt      <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            dram_en_rd   <= 1'b0;
            dram_addr_rd <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (beat) begin
                ret_cnt <= next_ret;
            end
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner        <= grant_sel;
                        last_grant   <= grant_sel;
                        base_q       <= sel_base;
                        len_q        <= sel_len;
                        issue_cnt    <= '0;
                        ret_cnt      <= '0;
                        ack0         <= ~grant_sel;
                        ack1         <= grant_sel;
                        // First word is issued in the same cycle as ack.
                        dram_en_rd   <= (sel_len != '0);
                        dram_addr_rd <= sel_base;
                        state        <= BURST;
                    end
                end
                BURST: begin
                    // issue_cnt is the index of the word on the bus now.
                    if ((len_q == '0) || (next_issue == len_q)) begin
                        dram_en_rd   <= 1'b0;
                        dram_addr_rd <= '0;
                        state        <= DRAIN;
                    end else begin
                        issue_cnt    <= next_issue;
                        dram_addr_rd <= base_q + ADDR_WIDTH'(next_issue);
                    end
                end
                DRAIN: begin
                    // Leave on the done beat so the next grant is sampled
                    // in the very next cycle.
                    if (last_beat || (ret_cnt == len_q)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_rd_sched.sv
module tb_dram_rd_sched;

    localparam int AW = 18;
    localparam int DW = 32;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          srstn = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0] base0 = '0, base1 = '0;
    logic [LW-1:0] len0 = '0, len1 = '0;
    logic          ack0, ack1, rvalid0, rvalid1, done0, done1;
    logic [DW-1:0] rdata;
    logic          dram_en_rd;
    logic [AW-1:0] dram_addr_rd;
    logic          dram_valid;
    logic [DW-1:0] dram_data_out;

    always #5 clk = ~clk;

    dram_rd_sched #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .LEN_WIDTH   (LW),
        .DRAM_LATENCY(1)
    ) dut (
        .clk          (clk),
        .srstn        (srstn),
        .req0         (req0),
        .base0        (base0),
        .len0         (len0),
        .req1         (req1),
        .base1        (base1),
        .len1         (len1),
        .ack0         (ack0),
        .ack1         (ack1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata        (rdata),
        .done0        (done0),
        .done1        (done1),
        .dram_en_rd   (dram_en_rd),
        .dram_addr_rd (dram_addr_rd),
        .dram_valid   (dram_valid),
        .dram_data_out(dram_data_out)
    );

    // DRAM model: latency 1, word at address i holds value i.
    logic          dv_q = 1'b0;
    logic [DW-1:0] dd_q = '0;
    logic          force_valid = 1'b0;
    always @(posedge clk) begin
        dv_q <= dram_en_rd;
        dd_q <= DW'(dram_addr_rd);
    end
    assign dram_valid    = dv_q | force_valid;
    assign dram_data_out = dd_q;

    typedef struct packed {
        logic          rv0;
        logic          rv1;
        logic          d0;
        logic          d1;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         beat_q[$];
    logic [AW-1:0] addr_q[$];
    logic [1:0]    ack_q[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    bit          mon_en  = 1'b0;
    int          cyc     = 0;
    int          done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
    endtask

    // Scoreboard monitors: pop and compare whenever the DUT presents output.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rvalid0 | rvalid1 | done0 | done1) begin
                beat_t act;
                act = '{rvalid0, rvalid1, done0, done1, rdata};
                if (done0 | done1) done_cyc = cyc;
                if (beat_q.size() == 0) check("unexpected_beat", 64'(act), 64'(0));
                else check("beat", 64'(act), 64'(beat_q.pop_front()));
            end
            if (dram_en_rd) begin
                if (addr_q.size() == 0) check("unexpected_rd", 64'(dram_addr_rd), 64'(0));
                else check("rd_addr", 64'(dram_addr_rd), 64'(addr_q.pop_front()));
            end
            if (ack0 | ack1) begin
                if (ack_q.size() == 0) check("unexpected_ack", 64'({ack0, ack1}), 64'(0));
                else check("ack", 64'({ack0, ack1}), 64'(ack_q.pop_front()));
            end
        end
    end

    task automatic push_burst(input bit id, input logic [AW-1:0] base, input int len);
        logic [AW-1:0] a;
        beat_t b;
        ack_q.push_back(id ? 2'b01 : 2'b10);
        if (len == 0) begin
            b = '{1'b0, 1'b0, !id, id, '0};
            beat_q.push_back(b);
        end
        for (int i = 0; i < len; i++) begin
            a = base + AW'(i);
            addr_q.push_back(a);
            b = '{!id, id, (i == len - 1) && !id, (i == len - 1) && id, DW'(a)};
            beat_q.push_back(b);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit id);
        bit got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            tick();
            if (id ? ack1 : ack0) begin
                got = 1'b1;
                if (id) req1 = 1'b0;
                else    req0 = 1'b0;
            end
        end
        if (!got) timeout(id ? "ack1_wait" : "ack0_wait");
    endtask

    task automatic wait_drain();
        bit empty = 1'b0;
        for (int i = 0; i < 200 && !empty; i++) begin
            tick();
            empty = (beat_q.size() == 0) && (addr_q.size() == 0) && (ack_q.size() == 0);
        end
        if (!empty) timeout("drain");
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({ack0, ack1, rvalid0, rvalid1, done0, done1, dram_en_rd, dram_addr_rd, rdata}), 64'(0));
    endtask

    initial begin
        int a_cyc, b_cyc, stray;

        // Reset state
        srstn = 1'b0;
        tick(); tick(); tick();
        check_all_zero("reset_outputs");
        srstn  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Simultaneous requests: requester 0 wins the first tie
        for (int r = 0; r < 2; r++) begin
            base0 = (r == 0) ? 18'h200 : 18'h400; len0 = 10'd3;
            base1 = (r == 0) ? 18'h300 : 18'h500; len1 = 10'd3;
            push_burst(1'b0, base0, 3);
            push_burst(1'b1, base1, 3);
            req0 = 1'b1; req1 = 1'b1;
            wait_ack(1'b0);
            wait_ack(1'b1);
            wait_drain();
        end

        // Single burst on requester 0
        base0 = 18'h100; len0 = 10'd4;
        push_burst(1'b0, base0, 4);
        req0 = 1'b1;
        wait_ack(1'b0);
        wait_drain();

        // Address wrap on requester 1
        base1 = 18'h3FFFE; len1 = 10'd4;
        push_burst(1'b1, base1, 4);
        req1 = 1'b1;
        wait_ack(1'b1);
        wait_drain();

        // len=0 on requester 1, then requester 0 re-grant timing
        base1 = 18'h900; len1 = 10'd0;
        push_burst(1'b1, base1, 0);
        req1 = 1'b1;
        wait_ack(1'b1);
        a_cyc = cyc;
        base0 = 18'hA00; len0 = 10'd2;
        push_burst(1'b0, base0, 2);
        req0 = 1'b1;
        wait_ack(1'b0);
        b_cyc = cyc;
        check("len0_done_timing", 64'(done_cyc - a_cyc), 64'(1));
        check("len0_regrant_gap", 64'(b_cyc - a_cyc), 64'(3));
        wait_drain();

        // Reset in the middle of a long burst
        mon_en = 1'b0;
        base0 = 18'h600; len0 = 10'd8;
        req0 = 1'b1;
        wait_ack(1'b0);
        tick(); tick(); tick();
        srstn = 1'b0;
        tick();
        check_all_zero("midburst_reset_outputs");
        srstn = 1'b1;
        tick();
        check_all_zero("after_reset_inflight_dropped");
        tick();
        mon_en = 1'b1;
        base0 = 18'h700; len0 = 10'd5;
        push_burst(1'b0, base0, 5);
        req0 = 1'b1;
        wait_ack(1'b0);
        wait_drain();

        // Stray dram_valid while idle
        force_valid = 1'b1;
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rvalid0 | rvalid1 | done0 | done1) stray++;
        end
        force_valid = 1'b0;
        check("stray_valid_idle", 64'(stray), 64'(0));
        tick();
        base1 = 18'h800; len1 = 10'd3;
        push_burst(1'b1, base1, 3);
        req1 = 1'b1;
        wait_ack(1'b1);
        wait_drain();

        check("queues_empty", 64'(beat_q.size() + addr_q.size() + ack_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_rd_sched.md
# dram_rd_sched

Read-port scheduler for the simulation DRAM model. It shares the single DRAM read port between two requesters: requester 0 is the weight fetcher and requester 1 is the feature-map fetcher. Each requester issues a burst request (base address, length). The scheduler grants round-robin, generates one read address per cycle, and routes the returned words with a per-requester valid and a burst-done pulse. The write port is not touched by this block.

## Interface
- DATA_WIDTH, 32, DRAM word width
- ADDR_WIDTH, 18, DRAM word-address width
- LEN_WIDTH, 10, burst length field width (max burst 2^LEN_WIDTH-1 words)
- DRAM_LATENCY, 1, cycles from en_rd sample to matching valid/data_out
- clk  in  1  clock
- srstn  in  1  reset; synchronous, active-low
- req0 / req1  in  1  burst request; held with base/len until ack
- base0 / base1  in  ADDR_WIDTH  first word address of burst
- len0 / len1  in  LEN_WIDTH  number of words; 0 allowed
- ack0 / ack1  out  1  one-cycle pulse: request accepted, base/len latched
- rvalid0 / rvalid1  out  1  rdata belongs to this requester this cycle
- rdata  out  DATA_WIDTH  returned word, shared by both requesters
- done0 / done1  out  1  one-cycle pulse with the last returned word of the burst
- dram_en_rd  out  1  to DRAM en_rd
- dram_addr_rd  out  ADDR_WIDTH  to DRAM addr_rd
- dram_valid  in  1  from DRAM valid
- dram_data_out  in  DATA_WIDTH  from DRAM data_out

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE: sample req0/req1.
  - If exactly one is high, grant it.
  - If both are high, grant the one that was not granted last. The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - On grant: latch base/len and owner, set issue_cnt=0 and ret_cnt=0, update the last-grant pointer, go to BURST.
- BURST: dram_en_rd=1, dram_addr_rd=base+issue_cnt, with address addition modulo 2^ADDR_WIDTH (wraps, no error). issue_cnt increments each cycle. After the cycle issuing word len-1, go to DRAIN.
- len=0: BURST issues nothing (dram_en_rd stays 0). The block goes straight to DRAIN and then reports done.
- DRAIN: issue nothing. Wait until ret_cnt reaches len, then go to IDLE.
- Return path (BURST and DRAIN):
  - On each dram_valid: rdata=dram_data_out and rvalid<owner>=1, then ret_cnt increments.
  - done<owner> is asserted on the beat where ret_cnt==len-1.
  - For len=0, done<owner> pulses alone in the first DRAIN cycle, with rvalid low.
- dram_valid while in IDLE is ignored: no rvalid, no counter change.
- Only one burst is outstanding at a time, so the owner is a single register and no reordering is needed.
- ack<owner> pulses in the first BURST cycle. A req still high in that cycle is ignored. The requester must drop req (or present a new request) by the time the block returns to IDLE, because a req high in IDLE is a new request.
- The ungranted requester's req stays pending without ack until a later IDLE.

## Timing
- Reset: all outputs 0 (ack*, rvalid*, done*, rdata, dram_en_rd, dram_addr_rd), state=IDLE, counters=0, last-grant=1.
- Reset mid-burst aborts the burst: outputs are 0 on the cycle after srstn is sampled low, and in-flight returns are dropped.
- Outputs:
  - ack*, dram_en_rd and dram_addr_rd are registered.
  - rvalid*, rdata and done* are combinational from dram_valid/dram_data_out and registered state; they carry no extra latency.
- Cycle timing, with req sampled in IDLE at cycle T and length N>0:
  - ack and the first dram_en_rd at T+1.
  - dram_en_rd high T+1..T+N, addresses base..base+N-1 in order.
  - rvalid high T+1+DRAM_LATENCY..T+N+DRAM_LATENCY.
  - done coincides with the last rvalid.
  - IDLE at the next cycle; the next grant is sampled there.
- Minimum gap between bursts: dram_en_rd low for DRAM_LATENCY+1 cycles.
- len=0: ack at T+1, done at T+2, IDLE at T+3.

## Test plan
- Single burst: DRAM preloaded data[i]=i. req0, base0=0x100, len0=4.
  - Expect ack0 one cycle, then dram_addr_rd 0x100..0x103 back-to-back.
  - Expect rvalid0 with rdata 0x100..0x103, done0 with 0x103, and rvalid1 never high.
- Simultaneous requests: req0 and req1 both high from reset, len=3 each.
  - Requester 0 is served first, then requester 1, and the returned data matches each base.
  - Repeat with both still requesting: requester 0 wins the next round only after requester 1 has been served.
- Wrap-around: base1=2^18-2, len1=4. Addresses are 0x3FFFE, 0x3FFFF, 0x00000, 0x00001, and the rdata follows.
- len=0 on req1: ack1, then done1 with no rvalid1 and no dram_en_rd; the block returns to IDLE within 3 cycles.
- Reset mid-burst: srstn low during BURST of len=8. Next cycle all outputs are 0; after release, a new req0 burst completes correctly.
- Stray dram_valid forced high in IDLE: no rvalid/done, and the next burst is returned intact.
